// File: rtl/tengigeth_loop_tester.sv
// -----------------------------------------------------------------------------
// tengigeth_loop_tester
//
// Traffic generator and checker for the ETH0 layer-2/layer-3 loopback turn.
// A run sends a burst of numbered test frames on soETH_Data, checks every
// frame that comes back on siETH_Data against a regenerated copy, and reports
// the outcome through MMIO counters and sticky flags.
//
// Ports
//   piETH_CoreClk      single clock for the whole block
//   piETH_CoreReset    synchronous, active-high reset
//   piMMIO_Start       run request, a rising edge starts a run
//   piMMIO_FrameLen    frame length in bytes (clamped to 60..1514)
//   piMMIO_FrameCnt    frames per run
//   piMMIO_ExpectSwap  returned frames expected with DA/SA exchanged
//   poMMIO_Busy        run in progress
//   poMMIO_Done        sticky end-of-run flag
//   poMMIO_Timeout     sticky flag, run ended by rx timeout
//   poMMIO_TxCnt       frames sent
//   poMMIO_RxCnt       frames received
//   poMMIO_ErrCnt      received frames containing an error
//   soETH_Data_*       generated frames (AXI4-Stream, 64-bit)
//   siETH_Data_*       returned frames (AXI4-Stream, 64-bit, never stalled)
// -----------------------------------------------------------------------------
module tengigeth_loop_tester #(
  parameter logic [47:0] gDstMac  = 48'h0002_0000_0002,
  parameter logic [47:0] gSrcMac  = 48'h0002_0000_0001,
  parameter logic [15:0] gTimeout = 16'hFFFF
) (
  input  logic        piETH_CoreClk,
  input  logic        piETH_CoreReset,
  input  logic        piMMIO_Start,
  input  logic [10:0] piMMIO_FrameLen,
  input  logic [15:0] piMMIO_FrameCnt,
  input  logic        piMMIO_ExpectSwap,
  output logic        poMMIO_Busy,
  output logic        poMMIO_Done,
  output logic        poMMIO_Timeout,
  output logic [15:0] poMMIO_TxCnt,
  output logic [15:0] poMMIO_RxCnt,
  output logic [15:0] poMMIO_ErrCnt,
  output logic [63:0] soETH_Data_tdata,
  output logic [7:0]  soETH_Data_tkeep,
  output logic        soETH_Data_tlast,
  output logic        soETH_Data_tvalid,
  input  logic        soETH_Data_tready,
  input  logic [63:0] siETH_Data_tdata,
  input  logic [7:0]  siETH_Data_tkeep,
  input  logic        siETH_Data_tlast,
  input  logic        siETH_Data_tvalid,
  output logic        siETH_Data_tready
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;

  // Content of frame byte iIdx for sequence number iSeq.
  function automatic logic [7:0] fnByte(input logic [10:0] iIdx, input logic [15:0] iSeq,
                                        input logic [47:0] iDa, input logic [47:0] iSa);
    logic [7:0] v;
    case (iIdx)
      11'd0:   v = iDa[47:40];
      11'd1:   v = iDa[39:32];
      11'd2:   v = iDa[31:24];
      11'd3:   v = iDa[23:16];
      11'd4:   v = iDa[15:8];
      11'd5:   v = iDa[7:0];
      11'd6:   v = iSa[47:40];
      11'd7:   v = iSa[39:32];
      11'd8:   v = iSa[31:24];
      11'd9:   v = iSa[23:16];
      11'd10:  v = iSa[15:8];
      11'd11:  v = iSa[7:0];
      11'd12:  v = 8'h88;
      11'd13:  v = 8'hB5;
      11'd14:  v = iSeq[15:8];
      11'd15:  v = iSeq[7:0];
      default: v = iIdx[7:0];
    endcase
    return v;
  endfunction

  // One 64-bit word of a frame; lanes outside iKeep are driven as zero.
  function automatic logic [63:0] fnWord(input logic [7:0] iWord, input logic [15:0] iSeq,
                                         input logic [47:0] iDa, input logic [47:0] iSa,
                                         input logic [7:0] iKeep);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      if (iKeep[k]) v[8*k +: 8] = fnByte({iWord, 3'(k)}, iSeq, iDa, iSa);
    end
    return v;
  endfunction

  function automatic logic [15:0] fnSatInc(input logic [15:0] iVal);
    return (iVal == 16'hFFFF) ? iVal : iVal + 16'd1;
  endfunction

  state_t      r_state;
  logic        r_startD;
  logic        r_busy, r_done, r_timeout;
  logic [7:0]  r_words, r_lastKeep;
  logic [15:0] r_frameCnt;
  logic        r_swap;
  logic [15:0] r_idle;
  logic [7:0]  r_txWord;
  logic [15:0] r_txSeq;
  logic        r_txValid, r_txLast;
  logic [63:0] r_txData;
  logic [7:0]  r_txKeep;
  logic [15:0] r_txCnt, r_rxCnt, r_errCnt;
  logic [7:0]  r_rxWord;
  logic [15:0] r_rxSeq;
  logic        r_rxErr, r_rxDiscard;

  // Length clamp and word geometry of the length presented at start.
  logic [10:0] w_lenClamp, w_lenPlus;
  logic [7:0]  w_startWords, w_startLastKeep;
  logic        w_startEdge;

  assign w_lenClamp      = (piMMIO_FrameLen < 11'd60)   ? 11'd60 :
                           (piMMIO_FrameLen > 11'd1514) ? 11'd1514 : piMMIO_FrameLen;
  assign w_lenPlus       = w_lenClamp + 11'd7;
  assign w_startWords    = w_lenPlus[10:3];
  assign w_startLastKeep = (w_lenClamp[2:0] == 3'd0) ? 8'hFF : ((8'd1 << w_lenClamp[2:0]) - 8'd1);
  assign w_startEdge     = piMMIO_Start & ~r_startD;

  // Word that follows the one currently presented on the tx stream.
  logic [7:0]  w_txNextWord, w_txNextKeep;
  logic [15:0] w_txNextSeq, w_txCntInc;
  logic        w_txNextLast, w_txFire;
  logic [63:0] w_txNextData, w_txFirstData;

  assign w_txNextWord  = r_txLast ? 8'd0 : r_txWord + 8'd1;
  assign w_txNextSeq   = r_txLast ? r_txSeq + 16'd1 : r_txSeq;
  assign w_txNextLast  = (w_txNextWord == r_words - 8'd1);
  assign w_txNextKeep  = w_txNextLast ? r_lastKeep : 8'hFF;
  assign w_txNextData  = fnWord(w_txNextWord, w_txNextSeq, gDstMac, gSrcMac, w_txNextKeep);
  assign w_txFirstData = fnWord(8'd0, 16'd0, gDstMac, gSrcMac, 8'hFF);
  assign w_txFire      = r_txValid & soETH_Data_tready;
  assign w_txCntInc    = fnSatInc(r_txCnt);

  // Expected word for the current rx position, with optional DA/SA swap.
  logic [47:0] w_expDa, w_expSa;
  logic        w_rxLastW, w_rxFire, w_rxBad, w_rxFrameBad;
  logic [7:0]  w_rxExpKeep, w_rxLaneBad;
  logic [63:0] w_rxExpData;

  assign w_expDa      = r_swap ? gSrcMac : gDstMac;
  assign w_expSa      = r_swap ? gDstMac : gSrcMac;
  assign w_rxLastW    = (r_rxWord == r_words - 8'd1);
  assign w_rxExpKeep  = w_rxLastW ? r_lastKeep : 8'hFF;
  assign w_rxExpData  = fnWord(r_rxWord, r_rxSeq, w_expDa, w_expSa, 8'hFF);
  assign w_rxFire     = siETH_Data_tvalid & r_busy;

  // Only lanes that both sides consider valid are compared byte-wise; a keep
  // disagreement is flagged on its own.
  always_comb begin
    w_rxLaneBad = '0;
    for (int k = 0; k < 8; k++) begin
      w_rxLaneBad[k] = siETH_Data_tkeep[k] & w_rxExpKeep[k] &
                       (siETH_Data_tdata[8*k +: 8] != w_rxExpData[8*k +: 8]);
    end
  end

  assign w_rxBad      = (|w_rxLaneBad) | (siETH_Data_tkeep != w_rxExpKeep) |
                        (siETH_Data_tlast != w_rxLastW);
  assign w_rxFrameBad = r_rxDiscard | r_rxErr | w_rxBad;

  // Run control and tx generator. WAIT_RX checks the registered rx count so
  // a frame counted in the same cycle is seen one cycle later.
  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset) begin
      r_state    <= IDLE;
      r_startD   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_words    <= '0;
      r_lastKeep <= '0;
      r_frameCnt <= '0;
      r_swap     <= 1'b0;
      r_idle     <= '0;
      r_txWord   <= '0;
      r_txSeq    <= '0;
      r_txValid  <= 1'b0;
      r_txLast   <= 1'b0;
      r_txData   <= '0;
      r_txKeep   <= '0;
      r_txCnt    <= '0;
    end else begin
      r_startD <= piMMIO_Start;
      case (r_state)
        IDLE: begin
          if (w_startEdge) begin
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_txCnt    <= '0;
            r_idle     <= '0;
            r_words    <= w_startWords;
            r_lastKeep <= w_startLastKeep;
            r_frameCnt <= piMMIO_FrameCnt;
            r_swap     <= piMMIO_ExpectSwap;
            r_busy     <= 1'b1;
            r_txWord   <= '0;
            r_txSeq    <= '0;
            if (piMMIO_FrameCnt == 16'd0) begin
              r_state <= WAIT_RX;
            end else begin
              r_state   <= SEND;
              r_txValid <= 1'b1;
              r_txData  <= w_txFirstData;
              r_txKeep  <= 8'hFF;
              r_txLast  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (w_txFire) begin
            if (r_txLast) r_txCnt <= w_txCntInc;
            if (r_txLast && (w_txCntInc == r_frameCnt)) begin
              r_state   <= WAIT_RX;
              r_txValid <= 1'b0;
              r_txData  <= '0;
              r_txKeep  <= '0;
              r_txLast  <= 1'b0;
            end else begin
              r_txWord <= w_txNextWord;
              r_txSeq  <= w_txNextSeq;
              r_txData <= w_txNextData;
              r_txKeep <= w_txNextKeep;
              r_txLast <= w_txNextLast;
            end
          end
        end
        WAIT_RX: begin
          if (r_rxCnt == r_frameCnt) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_rxFire) begin
            r_idle <= '0;
          end else if (r_idle == gTimeout - 16'd1) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_idle <= r_idle + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Rx checker. A frame missing tlast at its last word is marked bad and the
  // rest of it is dropped until tlast, which is where it gets counted.
  always_ff @(posedge piETH_CoreClk) begin
    if (piETH_CoreReset) begin
      r_rxCnt     <= '0;
      r_errCnt    <= '0;
      r_rxWord    <= '0;
      r_rxSeq     <= '0;
      r_rxErr     <= 1'b0;
      r_rxDiscard <= 1'b0;
    end else if ((r_state == IDLE) && w_startEdge) begin
      r_rxCnt     <= '0;
      r_errCnt    <= '0;
      r_rxWord    <= '0;
      r_rxSeq     <= '0;
      r_rxErr     <= 1'b0;
      r_rxDiscard <= 1'b0;
    end else if (w_rxFire) begin
      if (siETH_Data_tlast) begin
        r_rxCnt     <= fnSatInc(r_rxCnt);
        if (w_rxFrameBad) r_errCnt <= fnSatInc(r_errCnt);
        r_rxWord    <= '0;
        r_rxSeq     <= r_rxSeq + 16'd1;
        r_rxErr     <= 1'b0;
        r_rxDiscard <= 1'b0;
      end else if (r_rxDiscard) begin
        r_rxDiscard <= 1'b1;
      end else if (w_rxLastW) begin
        r_rxDiscard <= 1'b1;
        r_rxErr     <= 1'b1;
      end else begin
        r_rxWord <= r_rxWord + 8'd1;
        r_rxErr  <= r_rxErr | w_rxBad;
      end
    end
  end

  assign poMMIO_Busy       = r_busy;
  assign poMMIO_Done       = r_done;
  assign poMMIO_Timeout    = r_timeout;
  assign poMMIO_TxCnt      = r_txCnt;
  assign poMMIO_RxCnt      = r_rxCnt;
  assign poMMIO_ErrCnt     = r_errCnt;
  assign soETH_Data_tdata  = r_txData;
  assign soETH_Data_tkeep  = r_txKeep;
  assign soETH_Data_tlast  = r_txLast;
  assign soETH_Data_tvalid = r_txValid;
  assign siETH_Data_tready = 1'b1;

endmodule

// File: tb/tb_tengigeth_loop_tester.sv
// -----------------------------------------------------------------------------
// tb_tengigeth_loop_tester
//
// Drives tengigeth_loop_tester with directed runs. The tx stream is fed back
// into the rx port through a small loop model that can swap MACs, corrupt a
// byte, truncate a frame or drop a frame. A monitor compares every accepted
// tx word with frames rebuilt from the frame layout.
// -----------------------------------------------------------------------------
module tb_tengigeth_loop_tester;

  localparam logic [47:0] TB_DST = 48'h0002_0000_0002;
  localparam logic [47:0] TB_SRC = 48'h0002_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] inLen = 11'd64;
  logic [15:0] inCnt = 16'd1;
  logic        inSwap = 1'b0;
  logic        busy, done, tmo;
  logic [15:0] txCnt, rxCnt, errCnt;
  logic [63:0] txData;
  logic [7:0]  txKeep;
  logic        txLast, txValid;
  logic        txReady = 1'b1;
  logic [63:0] rxData;
  logic [7:0]  rxKeep;
  logic        rxLast, rxValid, rxReady;

  int checks = 0;
  int failures = 0;

  // Loop model controls
  logic randReady = 1'b0;
  logic swapLoop = 1'b0;
  int   corruptFrame = -1;
  int   truncFrame = -1;
  int   dropFrame = -1;

  // Tracker of the accepted tx position, used by the loop model and monitor
  logic trkClear = 1'b0;
  int   tbWord = 0;
  int   tbFrame = 0;
  int   tbLc = 64;

  // Monitor results
  int          streamErr = 0;
  int          lastWords = 0;
  logic [7:0]  lastKeep = 8'h00;
  logic [63:0] word0F0 = '0;
  logic [63:0] word1F0 = '0;
  logic        prevStall = 1'b0;
  logic [63:0] prevData = '0;
  logic [7:0]  prevKeep = '0;
  logic        prevLast = 1'b0;

  tengigeth_loop_tester #(
    .gDstMac (TB_DST),
    .gSrcMac (TB_SRC),
    .gTimeout(16'd100)
  ) dut (
    .piETH_CoreClk    (clk),
    .piETH_CoreReset  (rst),
    .piMMIO_Start     (start),
    .piMMIO_FrameLen  (inLen),
    .piMMIO_FrameCnt  (inCnt),
    .piMMIO_ExpectSwap(inSwap),
    .poMMIO_Busy      (busy),
    .poMMIO_Done      (done),
    .poMMIO_Timeout   (tmo),
    .poMMIO_TxCnt     (txCnt),
    .poMMIO_RxCnt     (rxCnt),
    .poMMIO_ErrCnt    (errCnt),
    .soETH_Data_tdata (txData),
    .soETH_Data_tkeep (txKeep),
    .soETH_Data_tlast (txLast),
    .soETH_Data_tvalid(txValid),
    .soETH_Data_tready(txReady),
    .siETH_Data_tdata (rxData),
    .siETH_Data_tkeep (rxKeep),
    .siETH_Data_tlast (rxLast),
    .siETH_Data_tvalid(rxValid),
    .siETH_Data_tready(rxReady)
  );

  always #5 clk = ~clk;

  // Expected content of byte i of frame f
  function automatic logic [7:0] tbByte(input int f, input int i);
    logic [47:0] da, sa;
    logic [15:0] seq;
    logic [31:0] iv;
    da  = TB_DST;
    sa  = TB_SRC;
    seq = f[15:0];
    iv  = i;
    if (i < 6)        return da[8*(5-i) +: 8];
    else if (i < 12)  return sa[8*(11-i) +: 8];
    else if (i == 12) return 8'h88;
    else if (i == 13) return 8'hB5;
    else if (i == 14) return seq[15:8];
    else if (i == 15) return seq[7:0];
    else              return iv[7:0];
  endfunction

  // Tracker of accepted tx words
  always @(posedge clk) begin
    if (trkClear) begin
      tbWord  <= 0;
      tbFrame <= 0;
    end else if (txValid && txReady) begin
      if (txLast) begin
        tbWord  <= 0;
        tbFrame <= tbFrame + 1;
      end else begin
        tbWord <= tbWord + 1;
      end
    end
  end

  // Loop model: passes accepted tx words to rx, optionally modified
  logic [63:0] modData;
  logic        forceLast, suppress;
  logic [47:0] mDst, mSrc;
  always_comb begin
    mDst      = TB_DST;
    mSrc      = TB_SRC;
    modData   = txData;
    forceLast = 1'b0;
    suppress  = 1'b0;
    if (swapLoop && tbWord == 0) begin
      for (int k = 0; k < 6; k++) modData[8*k +: 8] = mSrc[8*(5-k) +: 8];
      modData[55:48] = mDst[47:40];
      modData[63:56] = mDst[39:32];
    end
    if (swapLoop && tbWord == 1) begin
      for (int k = 0; k < 4; k++) modData[8*k +: 8] = mDst[8*(3-k) +: 8];
    end
    if (tbFrame == corruptFrame && tbWord == 2) modData[39:32] = txData[39:32] ^ 8'h01;
    if (tbFrame == truncFrame && tbWord == 3) forceLast = 1'b1;
    if ((tbFrame == truncFrame && tbWord > 3) || tbFrame == dropFrame) suppress = 1'b1;
  end

  assign rxData  = modData;
  assign rxKeep  = txKeep;
  assign rxLast  = txLast | forceLast;
  assign rxValid = txValid & txReady & ~suppress;

  // tx ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      txReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // tx stream monitor
  always @(negedge clk) begin
    int we;
    logic [7:0] ek;
    we = (tbLc + 7) / 8;
    ek = ((tbLc % 8) == 0) ? 8'hFF : 8'((1 << (tbLc % 8)) - 1);
    if (prevStall && (txData !== prevData || txKeep !== prevKeep || txLast !== prevLast || txValid !== 1'b1))
      streamErr = streamErr + 1;
    if (txValid && txReady) begin
      for (int k = 0; k < 8; k++) begin
        if (tbWord * 8 + k < tbLc && txData[8*k +: 8] !== tbByte(tbFrame, tbWord * 8 + k))
          streamErr = streamErr + 1;
      end
      if (txKeep !== ((tbWord == we - 1) ? ek : 8'hFF)) streamErr = streamErr + 1;
      if (txLast !== (tbWord == we - 1)) streamErr = streamErr + 1;
      if (tbFrame == 0 && tbWord == 0) word0F0 = txData;
      if (tbFrame == 0 && tbWord == 1) word1F0 = txData;
      if (txLast) begin
        lastWords = tbWord + 1;
        lastKeep  = txKeep;
      end
    end
    prevStall = txValid & ~txReady;
    prevData  = txData;
    prevKeep  = txKeep;
    prevLast  = txLast;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one run: set parameters and give a one-cycle start pulse
  task automatic applyStimulus(input logic [10:0] len, input logic [15:0] cnt, input logic swp);
    @(negedge clk);
    trkClear  = 1'b1;
    inLen     = len;
    inCnt     = cnt;
    inSwap    = swp;
    tbLc      = (len < 60) ? 60 : ((len > 1514) ? 1514 : int'(len));
    streamErr = 0;
    lastWords = 0;
    lastKeep  = 8'h00;
    start     = 1'b1;
    @(negedge clk);
    trkClear = 1'b0;
    start    = 1'b0;
  endtask

  // Let a run finish; counts busy cycles and busy cycles without tx valid
  task automatic runToEnd(input int budget, output int busyCyc, output int waitCyc);
    int n;
    n = 0;
    busyCyc = 0;
    waitCyc = 0;
    while (busy && n < budget) begin
      busyCyc++;
      if (!txValid) waitCyc++;
      @(negedge clk);
      n++;
    end
    checkOutput("run_end_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bc, wc;
    repeat (3) @(negedge clk);
    // Reset values
    checkOutput("rst_tvalid", {63'd0, txValid}, 64'd0);
    checkOutput("rst_tlast", {63'd0, txLast}, 64'd0);
    checkOutput("rst_tdata", txData, 64'd0);
    checkOutput("rst_tkeep", {56'd0, txKeep}, 64'd0);
    checkOutput("rst_rx_tready", {63'd0, rxReady}, 64'd1);
    checkOutput("rst_flags", {61'd0, busy, done, tmo}, 64'd0);
    checkOutput("rst_counters", {16'd0, txCnt, rxCnt, errCnt}, 64'd0);
    rst = 1'b0;

    // L=64, one frame, pure loopback
    applyStimulus(11'd64, 16'd1, 1'b0);
    runToEnd(200, bc, wc);
    checkOutput("l64_busy_le10", {63'd0, (bc <= 10)}, 64'd1);
    checkOutput("l64_words", lastWords, 64'd8);
    checkOutput("l64_lastkeep", {56'd0, lastKeep}, 64'hFF);
    checkOutput("l64_word0", word0F0, 64'h0200020000000200);
    checkOutput("l64_word1", word1F0, 64'h0000B58801000000);
    checkOutput("l64_stream", streamErr, 64'd0);
    checkOutput("l64_counts", {16'd0, txCnt, rxCnt, errCnt}, {16'd0, 16'd1, 16'd1, 16'd0});
    checkOutput("l64_timeout", {63'd0, tmo}, 64'd0);

    // L=61: short last word
    applyStimulus(11'd61, 16'd1, 1'b0);
    runToEnd(200, bc, wc);
    checkOutput("l61_words", lastWords, 64'd8);
    checkOutput("l61_lastkeep", {56'd0, lastKeep}, 64'h1F);
    checkOutput("l61_err", {48'd0, errCnt}, 64'd0);

    // L=2000 clamps to 1514
    applyStimulus(11'd2000, 16'd1, 1'b0);
    runToEnd(1000, bc, wc);
    checkOutput("l2000_words", lastWords, 64'd190);
    checkOutput("l2000_lastkeep", {56'd0, lastKeep}, 64'h03);
    checkOutput("l2000_stream", streamErr, 64'd0);
    checkOutput("l2000_rx_err", {32'd0, rxCnt, errCnt}, {32'd0, 16'd1, 16'd0});

    // FrameCnt=0 ends without sending
    applyStimulus(11'd64, 16'd0, 1'b0);
    runToEnd(50, bc, wc);
    checkOutput("cnt0_counts", {16'd0, txCnt, rxCnt, errCnt}, 64'd0);

    // Swapping loop, 100 frames of 1514 bytes
    swapLoop = 1'b1;
    applyStimulus(11'd1514, 16'd100, 1'b1);
    runToEnd(30000, bc, wc);
    checkOutput("swap1_rx_err", {32'd0, rxCnt, errCnt}, {32'd0, 16'd100, 16'd0});
    applyStimulus(11'd1514, 16'd100, 1'b0);
    runToEnd(30000, bc, wc);
    checkOutput("swap0_rx_err", {32'd0, rxCnt, errCnt}, {32'd0, 16'd100, 16'd100});
    swapLoop = 1'b0;

    // Random tx backpressure, 20 frames of 300 bytes
    randReady = 1'b1;
    applyStimulus(11'd300, 16'd20, 1'b0);
    runToEnd(10000, bc, wc);
    randReady = 1'b0;
    checkOutput("rnd_stream", streamErr, 64'd0);
    checkOutput("rnd_words", lastWords, 64'd38);
    checkOutput("rnd_lastkeep", {56'd0, lastKeep}, 64'h0F);
    checkOutput("rnd_counts", {16'd0, txCnt, rxCnt, errCnt}, {16'd0, 16'd20, 16'd20, 16'd0});

    // Corrupt byte 20 of frame 3
    corruptFrame = 3;
    applyStimulus(11'd64, 16'd5, 1'b0);
    runToEnd(500, bc, wc);
    corruptFrame = -1;
    checkOutput("corrupt_rx_err", {32'd0, rxCnt, errCnt}, {32'd0, 16'd5, 16'd1});

    // Truncate frame 2 with an early tlast
    truncFrame = 2;
    applyStimulus(11'd64, 16'd5, 1'b0);
    runToEnd(500, bc, wc);
    truncFrame = -1;
    checkOutput("trunc_rx_err", {32'd0, rxCnt, errCnt}, {32'd0, 16'd5, 16'd1});

    // Drop the last of 4 frames: timeout after 100 idle cycles
    dropFrame = 3;
    applyStimulus(11'd64, 16'd4, 1'b0);
    runToEnd(1000, bc, wc);
    dropFrame = -1;
    checkOutput("drop_timeout", {63'd0, tmo}, 64'd1);
    checkOutput("drop_idle_cycles", wc, 64'd100);
    checkOutput("drop_counts", {16'd0, txCnt, rxCnt, errCnt}, {16'd0, 16'd4, 16'd3, 16'd0});

    // Reset mid-frame, then a clean run
    applyStimulus(11'd300, 16'd3, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_tx", {txData, txKeep, txLast, txValid}, '0);
    checkOutput("mid_rst_flags", {60'd0, rxReady, busy, done, tmo}, 64'h8);
    checkOutput("mid_rst_counters", {16'd0, txCnt, rxCnt, errCnt}, 64'd0);
    rst = 1'b0;
    applyStimulus(11'd64, 16'd2, 1'b0);
    runToEnd(500, bc, wc);
    checkOutput("after_rst_counts", {16'd0, txCnt, rxCnt, errCnt}, {16'd0, 16'd2, 16'd2, 16'd0});
    checkOutput("after_rst_timeout", {63'd0, tmo}, 64'd0);
    checkOutput("after_rst_stream", streamErr, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
